instruction_fifo: RTL
=====================

# instruction_fifo

- Buffers decoded instructions, with their operands, between instruction fetch and the execution stage.
- Fetch pushes one decoded instruction per cycle through the `ififo_*` port group.
- Execution sees the oldest entry show-ahead and pops it when consumed.
- A flush from execution discards all buffered entries on a jump or suspend.

## Interface

Parameters:
- `DECODED_INSN_SIZE`, default 12: width of a decoded instruction word.
- `OPERAND_SIZE`, default 8: width of the operand carried with each entry.
- `DEPTH_LOG2`, default 2: log2 of entry count (default depth 4).

Ports:
- `clk`  in  1  clock; all activity on the positive edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ififo_di`  in  `DECODED_INSN_SIZE`  decoded instruction to push.
- `ififo_operand`  in  `OPERAND_SIZE`  operand to push; stored unchanged even for instructions without an operand.
- `ififo_shift`  in  1  push strobe, one entry per cycle high.
- `ififo_full`  out  1  high when the FIFO holds `2**DEPTH_LOG2` entries.
- `ififo_empty`  out  1  high when the FIFO holds 0 entries.
- `flush`  in  1  discard all entries (asserted by execute on jump_enable or suspend).
- `exec_insn`  out  `DECODED_INSN_SIZE`  head entry's instruction.
- `exec_operand`  out  `OPERAND_SIZE`  head entry's operand.
- `exec_valid`  out  1  head entry present; equals `!ififo_empty`.
- `exec_take`  in  1  pop strobe; consumes the head entry.
- `ififo_count`  out  `DEPTH_LOG2+1`  number of entries held.

## Operation

Storage:
- Circular buffer of `2**DEPTH_LOG2` entries, each `{insn, operand}`.
- Write pointer and read pointer, each `DEPTH_LOG2` bits, wrap modulo depth.
- Count register, `DEPTH_LOG2+1` bits.

Show-ahead read:
- `exec_insn` and `exec_operand` are driven combinationally from the entry at the read pointer.
- They hold the last-read or zero storage contents when empty; consumers qualify them with `exec_valid`.

Per-edge priority (highest first):
1. `flush`: both pointers and count go to 0. Any simultaneous `ififo_shift` or `exec_take` is ignored, and the pushed word is dropped.
2. Push accepted when `ififo_shift && (!ififo_full || exec_take)`:
   - write entry at the write pointer;
   - increment the write pointer.
3. Pop accepted when `exec_take && !ififo_empty`:
   - increment the read pointer.

Count update and flags:
- Count += push accepted, -= pop accepted. Push and pop together leave count unchanged; this includes the full and the 1-entry cases.
- Push while full without a simultaneous pop is dropped, and state is unchanged. Fetch must not do this; the bench flags it as a protocol error.
- Pop while empty is ignored, including when a push occurs the same cycle. The new entry is not bypassed to execute.
- `ififo_full`, `ififo_empty` and `ififo_count` are registered and derived from the post-edge count.
- No state machine beyond pointers and count. The full/empty distinction comes from the count, not from pointer comparison.

Reset (`reset_n` low, asynchronous, any time including mid-push):
- pointers, count and all storage = 0;
- `ififo_empty` = 1, `ififo_full` = 0, `ififo_count` = 0, `exec_valid` = 0, `exec_insn` = 0, `exec_operand` = 0.
- Operation resumes on the first rising edge after `reset_n` deasserts.

## Timing

- Push latency: an entry pushed at edge N appears on `exec_*` with `exec_valid` = 1 in the cycle after edge N, if the FIFO was empty.
- Pop: `exec_take` high at edge N presents the next entry (or `exec_valid` = 0) after edge N.
- Throughput: one push and one pop per cycle sustained at any occupancy, including full.
- Flush: takes effect at the edge where it is sampled high. `ififo_empty` = 1 and `exec_valid` = 0 from the next cycle. A push in the cycle after flush is accepted normally.
- Wrap-around: pointers roll from `2**DEPTH_LOG2-1` to 0 with no bubble.

## Test plan

- **Reset then fill:** reset, then push insns 0x101..0x104 on consecutive cycles with no pop. Required:
  - count goes 1, 2, 3, 4;
  - `ififo_full` = 1 after the 4th edge;
  - `exec_insn` = 0x101 throughout.
- **Drain:** from full, pop 4 times. Required:
  - `exec_insn` reads 0x102, 0x103, 0x104 in sequence;
  - then `ififo_empty` = 1, `exec_valid` = 0, count = 0.
- **Full push+pop and wrap-around:** from full, push and pop together for 6 cycles with insns 0x201..0x206. Required:
  - count stays 4 and `ififo_full` stays 1;
  - pops yield 0x101..0x104, 0x201, 0x202;
  - pointers have wrapped.
- **Flush:** with 3 entries held, assert flush together with push 0x3FF and pop. Required:
  - next cycle count = 0, `exec_valid` = 0;
  - a following push of 0x301 makes `exec_insn` = 0x301.
- **Empty boundaries:** pop while empty, and push+pop together while empty. Required:
  - the plain pop leaves the FIFO unchanged;
  - the simultaneous case ends with count = 1 and the pushed entry at the head.
- **Asynchronous reset mid-stream:** assert `reset_n` low between edges with 2 entries held. Required, immediately and without waiting for a clock edge:
  - `ififo_empty` = 1, `ififo_count` = 0, `exec_insn` = 0.

Source files
------------

// File: rtl/instruction_fifo.sv
// rtl/instruction_fifo.sv - show-ahead FIFO of decoded instructions between fetch and execute
module instruction_fifo #(
    parameter int DECODED_INSN_SIZE = 12,
    parameter int OPERAND_SIZE      = 8,
    parameter int DEPTH_LOG2        = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DECODED_INSN_SIZE-1:0] ififo_di,
    input  logic [OPERAND_SIZE-1:0]      ififo_operand,
    input  logic                         ififo_shift,
    output logic                         ififo_full,
    output logic                         ififo_empty,
    input  logic                         flush,
    output logic [DECODED_INSN_SIZE-1:0] exec_insn,
    output logic [OPERAND_SIZE-1:0]      exec_operand,
    output logic                         exec_valid,
    input  logic                         exec_take,
    output logic [DEPTH_LOG2:0]          ififo_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WIDTH = DECODED_INSN_SIZE + OPERAND_SIZE;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  push_ok, pop_ok;

    // Flush wins over everything; a pop makes room for a push even when full.
    always_comb begin
        push_ok  = ififo_shift && (!full_q || exec_take) && !flush;
        pop_ok   = exec_take && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
        // Count never exceeds DEPTH, so its top bit alone marks full.
        full_d  = count_d[DEPTH_LOG2];
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= {ififo_di, ififo_operand};
        end
    end

    assign {exec_insn, exec_operand} = mem_q[rd_ptr_q];
    assign exec_valid  = !empty_q;
    assign ififo_full  = full_q;
    assign ififo_empty = empty_q;
    assign ififo_count = count_q;
endmodule
